// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, transmitter FSM encoding and the default window base.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is accepted only when a pop frees the
// head slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART 8N1 transmitter on the core data port: TXDATA pushes into a FIFO,
// STATUS is read combinationally, the FSM serialises queued bytes onto txd.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        txd
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e   state;
  logic [CW-1:0] cnt;
  logic [2:0]  bitidx;
  logic [7:0]  shift;
  logic        ovf;
  logic        push, pop, full, empty, ovf_set, ovf_clr, is_status;
  logic [7:0]  fifo_dout;
  logic [31:0] status;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
  assign is_status = (addr[2] == OFF_STATUS[2]);
  assign push      = memwrite & sel & ~is_status;
  assign ovf_clr   = memwrite & sel & is_status & writedata[STAT_OVF];
  assign pop       = (state == StIdle) & ~empty;
  assign ovf_set   = push & full & ~pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    status             = '0;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY]  = (state != StIdle);
    status[STAT_OVF]   = ovf;
  end

  // TXDATA reads as zero; only STATUS returns live state.
  assign readdata = (sel && is_status) ? status : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      txd    <= 1'b1;
      cnt    <= '0;
      bitidx <= '0;
      shift  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      case (state)
        StIdle: begin
          if (!empty) begin
            shift <= fifo_dout;
            cnt   <= '0;
            txd   <= 1'b0;
            state <= StStart;
          end
        end
        StStart: begin
          if (cnt == CNT_MAX) begin
            cnt    <= '0;
            bitidx <= '0;
            txd    <= shift[0];
            state  <= StData;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (bitidx == 3'd7) begin
              txd   <= 1'b1;
              state <= StStop;
            end else begin
              // txd is registered, so present the next LSB alongside the shift
              shift  <= shift >> 1;
              txd    <= shift[1];
              bitidx <= bitidx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 8.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;
  logic        txd;

  int checks = 0;
  int passed = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok_q[$];
  bit         mon_en = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel       (sel),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  // Line-level reference: bit idx of an 8N1 frame (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Serial receiver: samples each bit in its middle and records the byte.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin : frame
        logic [7:0] b;
        bit ok;
        ok = 1'b1;
        b  = '0;
        repeat (2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) ok = 1'b0;
        rx_q.push_back(b);
        rx_ok_q.push_back(ok);
      end
    end
  end

  task automatic read_status(output logic [31:0] v);
    memwrite = 1'b0;
    addr     = BASE + 32'd4;
    #1;
    v = readdata;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    @(negedge clk);
    memwrite  = 1'b0;
    addr      = BASE + 32'd4;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] st;
    #1;
    checks++;
    if (txd !== 1'b1) $display("FAIL reset_txd got %b exp 1", txd);
    else passed++;
    read_status(st);
    checks++;
    if (st !== 32'h2) $display("FAIL reset_status got %h exp 00000002", st);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Start a frame, then reset asynchronously while the start bit is low.
    write_reg(BASE, 32'h0000_0012);
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b0) $display("FAIL reset_pre_txd got %b exp 0", txd);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) $display("FAIL reset_async_txd got %b exp 1", txd);
    else passed++;
    read_status(st);
    checks++;
    if (st !== 32'h2) $display("FAIL reset_async_status got %h exp 00000002", st);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte;
    logic [7:0]  b;
    logic [31:0] st;
    logic        exp_txd, exp_busy;
    int          errs;
    b = 8'h55;
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = BASE;
    writedata = 32'hABCD_0055;
    @(negedge clk);
    read_status(st);
    checks++;
    if (txd !== 1'b1 || st !== 32'h0)
      $display("FAIL single_after_write txd %b status %h exp 1 00000000", txd, st);
    else passed++;
    errs = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      #1;
      exp_txd  = (k <= 40) ? frame_bit(b, (k - 1) / CPB) : 1'b1;
      exp_busy = (k <= 40);
      if (txd !== exp_txd || readdata[2] !== exp_busy) begin
        if (errs == 0)
          $display("FAIL single_frame cycle %0d txd %b busy %b exp %b %b",
                   k, txd, readdata[2], exp_txd, exp_busy);
        errs++;
      end
      if (k == 40 || k == 41) begin
        checks++;
        if (readdata[2] !== exp_busy)
          $display("FAIL single_busy cycle %0d got %b exp %b", k, readdata[2], exp_busy);
        else passed++;
      end
    end
    checks++;
    if (errs != 0) $display("FAIL single_waveform errors %0d exp 0", errs);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0, b1;
    logic       exp_txd, exp_busy;
    int         errs;
    b0 = 8'h00;
    b1 = 8'hFF;
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = BASE;
    writedata = {24'h0, b0};
    @(negedge clk);
    writedata = {24'h0, b1};
    @(negedge clk);
    memwrite = 1'b0;
    addr     = BASE + 32'd4;
    errs = 0;
    for (int k = 1; k <= 82; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (k <= 40)      exp_txd = frame_bit(b0, (k - 1) / CPB);
      else if (k == 41) exp_txd = 1'b1;
      else if (k <= 81) exp_txd = frame_bit(b1, (k - 42) / CPB);
      else              exp_txd = 1'b1;
      exp_busy = (k != 41 && k != 82);
      if (txd !== exp_txd || readdata[2] !== exp_busy) begin
        if (errs == 0)
          $display("FAIL b2b_frame cycle %0d txd %b busy %b exp %b %b",
                   k, txd, readdata[2], exp_txd, exp_busy);
        errs++;
      end
    end
    checks++;
    if (errs != 0) $display("FAIL b2b_waveform errors %0d exp 0", errs);
    else passed++;
  endtask

  task automatic test_fill_overflow;
    logic [31:0] st, exp_st;
    int          n, accepted, queued;
    rx_q.delete();
    rx_ok_q.delete();
    n = 10;
    // One byte leaves for the shifter one edge after the first push.
    accepted = (n < DEPTH + 1) ? n : DEPTH + 1;
    queued   = accepted - 1;
    exp_st   = {28'h0, (n > accepted), 1'b1, (queued == 0), (queued == DEPTH)};
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      memwrite  = 1'b1;
      addr      = BASE;
      writedata = 32'h0000_0001 + i;
      @(negedge clk);
    end
    read_status(st);
    checks++;
    if (st !== exp_st) $display("FAIL fill_status got %h exp %h", st, exp_st);
    else passed++;
    write_reg(BASE + 32'd4, 32'h0000_0008);
    read_status(st);
    checks++;
    if (st !== (exp_st & 32'h7)) $display("FAIL ovf_clear got %h exp %h", st, exp_st & 32'h7);
    else passed++;
    wait_rx(accepted, accepted * 50 + 50);
    repeat (50) @(negedge clk);
    checks++;
    if (rx_q.size() != accepted)
      $display("FAIL fill_rx_count got %0d exp %0d", rx_q.size(), accepted);
    else passed++;
    for (int i = 0; i < accepted && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i + 1) || !rx_ok_q[i])
        $display("FAIL fill_rx_byte %0d got %h ok %0d exp %h", i, rx_q[i], rx_ok_q[i], 8'(i + 1));
      else passed++;
    end
    read_status(st);
    checks++;
    if (st !== 32'h2) $display("FAIL fill_drained got %h exp 00000002", st);
    else passed++;
  endtask

  task automatic test_decode;
    logic [31:0] st;
    rx_q.delete();
    rx_ok_q.delete();
    @(negedge clk);
    memwrite  = 1'b1;
    addr      = BASE + 32'd8;
    writedata = 32'h0000_0077;
    #1;
    checks++;
    if (sel !== 1'b0 || readdata !== 32'h0)
      $display("FAIL decode_base8 sel %b rd %h exp 0 00000000", sel, readdata);
    else passed++;
    @(negedge clk);
    addr = 32'h0000_0010;
    #1;
    checks++;
    if (sel !== 1'b0 || readdata !== 32'h0)
      $display("FAIL decode_0x10 sel %b rd %h exp 0 00000000", sel, readdata);
    else passed++;
    @(negedge clk);
    memwrite = 1'b0;
    addr     = BASE;
    #1;
    checks++;
    if (sel !== 1'b1 || readdata !== 32'h0)
      $display("FAIL decode_txdata_read sel %b rd %h exp 1 00000000", sel, readdata);
    else passed++;
    repeat (60) @(negedge clk);
    read_status(st);
    checks++;
    if (st !== 32'h2 || rx_q.size() != 0)
      $display("FAIL decode_no_push status %h rx %0d exp 00000002 0", st, rx_q.size());
    else passed++;
    write_reg(BASE + 32'd1, 32'h5A5A_5A3C);
    read_status(st);
    checks++;
    if (st !== 32'h0) $display("FAIL decode_base1_push got %h exp 00000000", st);
    else passed++;
    wait_rx(1, 100);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || !rx_ok_q[0])
      $display("FAIL decode_base1_byte count %0d exp 1 byte 3c", rx_q.size());
    else passed++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      logic [7:0]  exp_q[$];
      logic [7:0]  b;
      logic [31:0] rnd, st;
      int          n, g;
      n = $urandom_range(1, DEPTH + 1);
      rx_q.delete();
      rx_ok_q.delete();
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        b   = 8'($urandom);
        rnd = $urandom;
        exp_q.push_back(b);
        memwrite  = 1'b1;
        addr      = BASE | {30'h0, rnd[1:0]};
        writedata = {rnd[31:8], b};
        @(negedge clk);
        g = $urandom_range(0, 2);
        if (g > 0) begin
          memwrite = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      memwrite = 1'b0;
      wait_rx(n, n * 50 + 50);
      repeat (4) @(negedge clk);
      checks++;
      if (rx_q.size() != n) $display("FAIL rand_count round %0d got %0d exp %0d", r, rx_q.size(), n);
      else passed++;
      for (int i = 0; i < n && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i] || !rx_ok_q[i])
          $display("FAIL rand_byte round %0d idx %0d got %h ok %0d exp %h",
                   r, i, rx_q[i], rx_ok_q[i], exp_q[i]);
        else passed++;
      end
      read_status(st);
      checks++;
      if (st !== 32'h2) $display("FAIL rand_idle round %0d got %h exp 00000002", r, st);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0]  b0;
    logic [31:0] st;
    int          bad;
    mon_en = 1'b0;
    b0 = 8'($urandom) & 8'hF7;
    @(negedge clk);
    memwrite = 1'b1;
    addr     = BASE;
    writedata = {24'h0, b0};
    @(negedge clk);
    writedata = 32'h0000_00A5;
    @(negedge clk);
    writedata = 32'h0000_005A;
    @(negedge clk);
    memwrite = 1'b0;
    addr     = BASE + 32'd4;
    // Now two samples after the first push; data bit 3 spans samples 17..20.
    repeat (16) @(negedge clk);
    checks++;
    if (txd !== 1'b0) $display("FAIL midframe_bit3 got %b exp 0", txd);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) $display("FAIL midframe_txd got %b exp 1", txd);
    else passed++;
    read_status(st);
    checks++;
    if (st !== 32'h2) $display("FAIL midframe_status got %h exp 00000002", st);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL midframe_quiet low cycles %0d exp 0", bad);
    else passed++;
    read_status(st);
    checks++;
    if (st !== 32'h2) $display("FAIL midframe_after got %h exp 00000002", st);
    else passed++;
    rx_q.delete();
    rx_ok_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h0;
    writedata = 32'h0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    test_fill_overflow();
    test_decode();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
